// File: rtl/dma_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dma_pkg                                                               |
// | Shared states, transfer-mode and command-bit constants for the DMA.   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package dma_pkg;

  typedef enum logic [2:0] {
    SI = 3'd0,
    S0 = 3'd1,
    S1 = 3'd2,
    S2 = 3'd3,
    S3 = 3'd4,
    S4 = 3'd5
  } dma_state_t;

  localparam logic [1:0] DEMAND = 2'b00;
  localparam logic [1:0] SINGLE = 2'b01;
  localparam logic [1:0] BLOCK  = 2'b10;

  localparam int CMD_DISABLE   = 2;
  localparam int CMD_ROTATE    = 4;
  localparam int CMD_DREQ_LOW  = 6;
  localparam int CMD_DACK_HIGH = 7;

  // States in which the bus is owned and DACK is driven.
  function automatic logic is_xfer_state(input dma_state_t s);
    return (s == S1) || (s == S2) || (s == S3) || (s == S4);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dma_priority_timing_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dma_priority_timing_ctrl_if                                           |
// | Channel request/acknowledge and host hold handshake bundle.           |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface dma_priority_timing_ctrl_if #(
  parameter int NCH = 4
);
  logic [NCH-1:0] dreq;
  logic           hlda;
  logic           eop_n_in;
  logic           hrq;
  logic [NCH-1:0] dack;

  modport master (input dreq, hlda, eop_n_in, output hrq, dack);
  modport slave  (output dreq, hlda, eop_n_in, input hrq, dack);
endinterface
`default_nettype wire

// File: rtl/dma_priority_encoder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dma_priority_encoder                                                  |
// | Picks one requesting channel, fixed (lowest index) or rotating order. |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module dma_priority_encoder #(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0]         i_eff,
  input  logic [$clog2(NCH)-1:0] i_pointer,
  input  logic                   i_rotate,
  output logic [$clog2(NCH)-1:0] o_winner,
  output logic                   o_valid
);
  localparam int CW = $clog2(NCH);

  logic [CW-1:0] w_base;

  assign w_base = i_rotate ? i_pointer : '0;

  // Scan from the farthest offset down so the nearest hit to the base wins;
  // the CW-bit sum wraps naturally because NCH is a power of two.
  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (i_eff[w_base + CW'(i)]) begin
        o_valid  = 1'b1;
        o_winner = w_base + CW'(i);
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/dma_priority_timing_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dma_priority_timing_ctrl                                              |
// | DMA channel arbitration plus SI/S0..S4 host handshake and timing.     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module dma_priority_timing_ctrl
  import dma_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  dma_priority_timing_ctrl_if.master bus,
  input  logic [7:0]                command_reg,
  input  logic [NCH-1:0]            mask_reg,
  input  logic [NCH-1:0]            request_reg,
  input  logic [2*NCH-1:0]          mode_xfer,
  input  logic                      tc_in,
  output logic [$clog2(NCH)-1:0]    active_ch,
  output logic                      busy,
  output logic                      adv,
  output logic [NCH-1:0]            tc_out,
  output logic [NCH-1:0]            req_clr
);
  localparam int         CW       = $clog2(NCH);
  localparam logic [2:0] WAIT_CNT = 3'(WAIT_STATES);

  dma_state_t     r_state, w_next;
  logic [CW-1:0]  r_active, r_ptr, w_winner;
  logic [2:0]     r_wait;
  logic           w_valid, w_end, w_term, w_svc_done, w_adv;
  logic [NCH-1:0] w_sensed, w_eff, w_onehot, w_dack_act;
  logic [1:0]     w_mode;
  logic           w_unused_cmd;

  assign w_unused_cmd = ^{command_reg[5], command_reg[3], command_reg[1:0]};

  assign w_sensed = bus.dreq ^ {NCH{command_reg[CMD_DREQ_LOW]}};
  assign w_eff    = (w_sensed & ~mask_reg) | request_reg;
  assign w_onehot = {{(NCH-1){1'b0}}, 1'b1} << r_active;
  assign w_mode   = mode_xfer[{r_active, 1'b0} +: 2];
  assign w_end    = ~bus.eop_n_in | tc_in;

  dma_priority_encoder #(.NCH(NCH)) u_prio (
    .i_eff     (w_eff),
    .i_pointer (r_ptr),
    .i_rotate  (command_reg[CMD_ROTATE]),
    .o_winner  (w_winner),
    .o_valid   (w_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= SI;
      r_active <= '0;
      r_ptr    <= '0;
      r_wait   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == SI && w_next == S0)
        r_active <= w_winner;
      if (w_svc_done && command_reg[CMD_ROTATE])
        r_ptr <= r_active + 1'b1;
      r_wait <= (r_state == S3 && w_next == S3) ? r_wait + 3'd1 : 3'd0;
    end
  end

  // Loss of hlda in any owned state aborts without advancing or rotating.
  always_comb begin
    w_next     = r_state;
    w_adv      = 1'b0;
    w_term     = 1'b0;
    w_svc_done = 1'b0;
    unique case (r_state)
      SI: if (!command_reg[CMD_DISABLE] && w_valid) w_next = S0;
      S0: if (bus.hlda) w_next = S1;
      S1: w_next = bus.hlda ? S2 : SI;
      S2: w_next = bus.hlda ? S3 : SI;
      S3: begin
        if (!bus.hlda)              w_next = SI;
        else if (r_wait == WAIT_CNT) w_next = S4;
      end
      S4: begin
        w_next = SI;
        if (bus.hlda) begin
          w_adv      = 1'b1;
          w_svc_done = 1'b1;
          if (w_end) begin
            w_term = 1'b1;
          end else if (!mask_reg[r_active] &&
                       (w_mode == BLOCK || (w_mode == DEMAND && w_eff[r_active]))) begin
            w_next     = S1;
            w_svc_done = 1'b0;
          end
        end
      end
      default: w_next = SI;
    endcase
  end

  assign busy       = (r_state != SI);
  assign bus.hrq    = busy;
  assign w_dack_act = is_xfer_state(r_state) ? w_onehot : '0;
  assign bus.dack   = command_reg[CMD_DACK_HIGH] ? w_dack_act : ~w_dack_act;
  assign active_ch  = r_active;
  assign adv        = w_adv;
  assign tc_out     = w_term ? w_onehot : '0;
  assign req_clr    = w_term ? w_onehot : '0;
endmodule
`default_nettype wire

// File: tb/tb_dma_priority_timing_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_dma_priority_timing_ctrl                                           |
// | Random service scenarios against a transaction-level model.           |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_dma_priority_timing_ctrl;
  localparam int NCH = 4;
  localparam int W   = 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] command_reg;
  logic [3:0] mask_reg, request_reg;
  logic [7:0] mode_xfer;
  logic       tc_in;
  logic [1:0] active_ch;
  logic       busy, adv;
  logic [3:0] tc_out, req_clr;

  dma_priority_timing_ctrl_if #(.NCH(NCH)) bus ();

  dma_priority_timing_ctrl #(.NCH(NCH), .WAIT_STATES(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .command_reg (command_reg),
    .mask_reg    (mask_reg),
    .request_reg (request_reg),
    .mode_xfer   (mode_xfer),
    .tc_in       (tc_in),
    .active_ch   (active_ch),
    .busy        (busy),
    .adv         (adv),
    .tc_out      (tc_out),
    .req_clr     (req_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         ch;
    logic [3:0] dack;
    logic [3:0] tc;
    logic [3:0] rc;
    bit         fin;
  } adv_t;

  typedef struct {
    int ch;
    int nx;
    int dcyc;
  } svc_t;

  adv_t adv_q[$];
  svc_t svc_q[$];

  int   checks = 0;
  int   failures = 0;
  int   probe_seq = 0;
  int   probe_kind = 0;
  bit   mon_ignore = 1'b0;
  bit   host_manual = 1'b0;
  logic man_hlda = 1'b0;
  int   model_ptr = 0;

  // Host: grants hold after a random 0..2 cycle delay, releases with hrq.
  int hdelay = 0;
  always @(posedge clk) begin
    #2;
    if (host_manual) bus.hlda = man_hlda;
    else if (!bus.hrq) begin
      bus.hlda = 1'b0;
      hdelay   = $urandom_range(0, 2);
    end else if (!bus.hlda) begin
      if (hdelay == 0) bus.hlda = 1'b1;
      else hdelay--;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: consumes expectations whenever the DUT strobes adv or ends service.
  int   last_seq = 0;
  bit   prev_busy = 1'b0;
  int   n_adv = 0, n_dack = 0;
  bit   hrq_pend = 1'b0;
  int   hrq_exp = 0;
  always @(negedge clk) begin
    adv_t       e;
    svc_t       s;
    logic [3:0] inact;
    inact = command_reg[7] ? 4'b0000 : 4'b1111;
    if (mon_ignore || !reset_n) begin
      prev_busy = 1'b0; n_adv = 0; n_dack = 0; hrq_pend = 1'b0;
    end else begin
      if (hrq_pend) begin
        chk("hrq_after_s4", int'(bus.hrq), hrq_exp);
        hrq_pend = 1'b0;
      end
      if (busy && bus.dack != inact) n_dack++;
      if (adv) begin
        n_adv++;
        if (adv_q.size() == 0) chk("unexpected_adv", 1, 0);
        else begin
          e = adv_q.pop_front();
          chk("adv_ch",  int'(active_ch), e.ch);
          chk("adv_dack", int'(bus.dack), int'(e.dack));
          chk("tc_out",  int'(tc_out),  int'(e.tc));
          chk("req_clr", int'(req_clr), int'(e.rc));
          hrq_pend = 1'b1;
          hrq_exp  = e.fin ? 0 : 1;
        end
      end else begin
        chk("tc_quiet", int'(tc_out | req_clr), 0);
      end
      if (prev_busy && !busy) begin
        if (svc_q.size() == 0) chk("unexpected_service", 1, 0);
        else begin
          s = svc_q.pop_front();
          chk("svc_ch",        int'(active_ch), s.ch);
          chk("svc_adv_count", n_adv,  s.nx);
          chk("svc_dack_cyc",  n_dack, s.dcyc);
        end
        n_adv = 0; n_dack = 0;
      end
      prev_busy = busy;
    end
    if (probe_seq != last_seq) begin
      last_seq = probe_seq;
      case (probe_kind)
        1: begin
          chk("rst_hrq", int'(bus.hrq), 0);
          chk("rst_busy", int'(busy), 0);
          chk("rst_adv", int'(adv), 0);
          chk("rst_tc_out", int'(tc_out), 0);
          chk("rst_req_clr", int'(req_clr), 0);
          chk("rst_dack", int'(bus.dack), int'(inact));
          chk("rst_active_ch", int'(active_ch), 0);
        end
        2: begin
          chk("abort_hrq", int'(bus.hrq), 0);
          chk("abort_busy", int'(busy), 0);
          chk("abort_adv", int'(adv), 0);
          chk("abort_dack", int'(bus.dack), int'(inact));
        end
        3: begin
          chk("disabled_hrq", int'(bus.hrq), 0);
          chk("disabled_busy", int'(busy), 0);
        end
        default: begin
          chk("adv_queue_drained", adv_q.size(), 0);
          chk("svc_queue_drained", svc_q.size(), 0);
        end
      endcase
    end
  end

  task automatic do_probe(input int kind);
    probe_kind = kind;
    probe_seq++;
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    request_reg  = 4'b0;
    bus.dreq     = {4{command_reg[6]}};
    tc_in        = 1'b0;
    bus.eop_n_in = 1'b1;
  endtask

  task automatic wait_busy();
    for (int t = 0; t < 40; t++) begin
      @(posedge clk); #1;
      if (busy) return;
    end
    $display("FAIL wait_busy: got busy=0 expected busy=1 within 40 cycles");
    $fatal(1, "service never started");
  endtask

  // One service: random config, model predicts winner/transfers/termination.
  task automatic run_scenario();
    logic [7:0] cmd, modes;
    logic [3:0] m, r, d, eff, oh, dexp, tcv;
    int         win, k, mode, nx, cnt;
    bit         endsig, use_eop, term, masked, done;
    cmd    = 8'h00;
    cmd[4] = 1'($urandom_range(0, 1));
    cmd[6] = 1'($urandom_range(0, 1));
    cmd[7] = 1'($urandom_range(0, 1));
    do begin
      m   = 4'($urandom);
      r   = 4'($urandom) & 4'($urandom);
      d   = 4'($urandom);
      eff = (d & ~m) | r;
    end while (eff == 4'b0);
    modes        = 8'($urandom);
    mask_reg     = m;
    mode_xfer    = modes;
    tc_in        = 1'b0;
    bus.eop_n_in = 1'b1;
    if ($urandom_range(0, 7) == 0) begin
      cmd[2]      = 1'b1;
      command_reg = cmd;
      request_reg = r;
      bus.dreq    = d ^ {4{cmd[6]}};
      repeat (6) @(posedge clk);
      #1;
      do_probe(3);
      clear_inputs();
      return;
    end
    win = -1;
    for (int i = 0; i < 4; i++) begin
      int c;
      c = cmd[4] ? (model_ptr + i) % 4 : i;
      if (win < 0 && eff[c]) win = c;
    end
    mode    = int'(modes[2*win +: 2]);
    masked  = m[win];
    k       = $urandom_range(1, 4);
    use_eop = 1'($urandom_range(0, 1));
    endsig  = 1'b0;
    if (mode == 1 || mode == 3) begin
      k = 1; endsig = 1'($urandom_range(0, 1)); nx = 1; term = endsig;
    end else if (mode == 2) begin
      endsig = 1'b1; nx = masked ? 1 : k; term = masked ? (k == 1) : 1'b1;
    end else begin
      nx = masked ? 1 : k; term = 1'b0;
    end
    oh   = 4'b0001 << win;
    dexp = cmd[7] ? oh : ~oh;
    for (int j = 0; j < nx; j++) begin
      tcv = (term && j == nx - 1) ? oh : 4'b0000;
      adv_q.push_back('{win, dexp, tcv, tcv, j == nx - 1});
    end
    svc_q.push_back('{win, nx, nx * (4 + W)});
    if (cmd[4]) model_ptr = (win + 1) % 4;

    command_reg = cmd;
    request_reg = r;
    bus.dreq    = d ^ {4{cmd[6]}};
    if (endsig && k == 1) begin
      if (use_eop) bus.eop_n_in = 1'b0; else tc_in = 1'b1;
    end
    wait_busy();
    if (mode == 0 && !masked) begin
      bus.dreq    = (d & oh) ^ {4{cmd[6]}};
      request_reg = r & oh;
    end else begin
      bus.dreq    = {4{cmd[6]}};
      request_reg = 4'b0;
    end
    cnt = 0; done = 1'b0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(posedge clk); #1;
      if (!busy) done = 1'b1;
      else if (adv) cnt++;
      else if (cnt == k - 1) begin
        if (endsig) begin
          if (use_eop) bus.eop_n_in = 1'b0; else tc_in = 1'b1;
        end
        if (mode == 0) begin
          bus.dreq    = {4{cmd[6]}};
          request_reg = 4'b0;
        end
      end
    end
    if (!done) begin
      $display("FAIL service_end: got busy=1 expected busy=0 within 400 cycles");
      $fatal(1, "service never ended");
    end
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    do_probe(4);
  endtask

  // Manually drive the host so the state sequence S0,S1,S2.. is known.
  task automatic manual_start(input logic [7:0] cmd, input logic [3:0] req_dreq);
    host_manual  = 1'b1;
    man_hlda     = 1'b0;
    command_reg  = cmd;
    mask_reg     = 4'b0;
    request_reg  = 4'b0;
    mode_xfer    = 8'h55;
    bus.dreq     = req_dreq ^ {4{cmd[6]}};
    wait_busy();
    man_hlda = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    command_reg  = 8'h00;
    mask_reg     = 4'b0;
    request_reg  = 4'b0;
    mode_xfer    = 8'h00;
    tc_in        = 1'b0;
    bus.eop_n_in = 1'b1;
    bus.dreq     = 4'b0;
    reset_n      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_probe(1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // hlda lost in S2 of a ch1 transfer: no adv, pointer unchanged.
    svc_q.push_back('{1, 0, 2});
    manual_start(8'h90, 4'b0010);
    man_hlda = 1'b0;
    clear_inputs();
    @(posedge clk); #1;
    do_probe(2);
    host_manual = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int n = 0; n < 40; n++) run_scenario();

    // Asynchronous reset in S3 of a ch2 transfer.
    mon_ignore = 1'b1;
    manual_start(8'h80, 4'b0100);
    @(posedge clk); #1;
    reset_n = 1'b0;
    do_probe(1);
    @(posedge clk); #1;
    clear_inputs();
    man_hlda  = 1'b0;
    model_ptr = 0;
    @(posedge clk); #1;
    reset_n     = 1'b1;
    host_manual = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mon_ignore = 1'b0;

    for (int n = 0; n < 15; n++) run_scenario();

    do_probe(4);
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
